// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin arbiter sharing the single-port ROM read path
// between NUM_REQ requesters. Every access is IDLE -> ISSUE -> RESP (3 cycles).
module rom_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      busy,
    output logic                      rom_en,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data
);

    localparam int PTR_W = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              win_found;
    logic [PTR_W-1:0]  win_idx;
    logic [ADDR_W-1:0] win_addr;
    logic              win_onehot;

    // Winner search: first active request starting at ptr, wrapping around.
    // Outer loop walks the priority order, inner loop matches the requester
    // so every index stays a plain loop constant.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_addr  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!win_found && req[j] && ((int'(ptr_q) + i) % NUM_REQ) == j) begin
                    win_found = 1'b1;
                    win_idx   = PTR_W'(j);
                    win_addr  = req_addr[j*ADDR_W +: ADDR_W];
                end
            end
        end
        win_onehot = (win_addr != '0) && ((win_addr & (win_addr - 1'b1)) == '0);
    end

    // Next-state logic: address and error are captured once at the grant
    // decision, so later req_addr changes cannot disturb the access.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        err_d   = err_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    owner_d = win_idx;
                    err_d   = !win_onehot;
                    addr_d  = win_addr;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ptr_d   = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : PTR_W'(owner_q + 1'b1);
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset; reset abandons any access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
        end
    end

    // Outputs are pure decodes of registered state, so they are glitch-free
    // and at most one gnt / rsp_valid bit can ever be high.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt[i]       = (state_q == S_ISSUE) && (owner_q == PTR_W'(i));
            rsp_valid[i] = (state_q == S_RESP)  && (owner_q == PTR_W'(i));
        end
        busy     = (state_q != S_IDLE);
        rom_en   = (state_q == S_ISSUE) && !err_q;
        rom_addr = addr_q;
        rsp_err  = (state_q == S_RESP) && err_q;
        rsp_data = ((state_q == S_RESP) && !err_q) ? rom_data : '0;
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter (NUM_REQ=2) with a behavioural one-hot ROM.
module tb_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] req_addr;
    logic [1:0]  gnt;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data = 8'h00;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rom_arbiter #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy), .rom_en(rom_en),
        .rom_addr(rom_addr), .rom_data(rom_data)
    );

    // ROM stand-in: one-hot bit k reads (k+1)*0x11, registered on en.
    function automatic logic [7:0] rom_lookup(input logic [7:0] a);
        logic [7:0] d;
        d = 8'h00;
        for (int k = 0; k < 8; k++)
            if (a == (8'h01 << k)) d = 8'((k + 1) * 17);
        return d;
    endfunction

    always_ff @(posedge clk)
        if (rom_en) rom_data <= rom_lookup(rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One isolated access by requester r; req dropped during the gnt cycle.
    task automatic access(input int r, input logic [7:0] a, input logic [7:0] d, input logic e);
        req[r] = 1'b1;
        req_addr[r*8 +: 8] = a;
        @(posedge clk); @(negedge clk);
        chk("gnt", 32'(gnt), 32'(2'b01 << r));
        chk("busy_issue", 32'(busy), 1);
        chk("rom_en_issue", 32'(rom_en), 32'(!e));
        chk("rom_addr", 32'(rom_addr), 32'(a));
        req[r] = 1'b0;
        @(negedge clk);
        chk("rsp_valid", 32'(rsp_valid), 32'(2'b01 << r));
        chk("rsp_data", 32'(rsp_data), 32'(d));
        chk("rsp_err", 32'(rsp_err), 32'(e));
        chk("rom_en_resp", 32'(rom_en), 0);
        chk("gnt_resp", 32'(gnt), 0);
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_valid", 32'(rsp_valid), 0);
    endtask

    initial begin
        // 1: reset held 3 cycles with both requests active
        rst = 1'b1; req = 2'b11; req_addr = 16'h0201;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_gnt", 32'(gnt), 0);
            chk("rst_valid", 32'(rsp_valid), 0);
            chk("rst_rom_en", 32'(rom_en), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_rom_addr", 32'(rom_addr), 0);
            chk("rst_rsp_data", 32'(rsp_data), 0);
            chk("rst_rsp_err", 32'(rsp_err), 0);
        end
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("first_gnt", 32'(gnt), 32'h1);
        req = 2'b00;
        @(negedge clk);
        chk("first_data", 32'(rsp_data), 32'h11);
        @(negedge clk);

        // 2: single requester sweeps every legal address
        for (int k = 0; k < 8; k++)
            access(0, 8'(8'h01 << k), 8'((k + 1) * 17), 1'b0);

        // 4: illegal addresses on req1 (also leaves ptr at 0)
        access(1, 8'h03, 8'h00, 1'b1);
        access(1, 8'h00, 8'h00, 1'b1);

        // 3: contention with both requests held continuously
        req_addr = 16'h4004; req = 2'b11;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); @(negedge clk);
            chk("cont_gnt", 32'(gnt), (n % 2 == 0) ? 32'h1 : 32'h2);
            @(negedge clk);
            chk("cont_valid", 32'(rsp_valid), (n % 2 == 0) ? 32'h1 : 32'h2);
            chk("cont_data", 32'(rsp_data), (n % 2 == 0) ? 32'h33 : 32'h77);
            if (n == 3) req = 2'b00;
            @(negedge clk);
        end

        // 5: reset during ISSUE of a req0 access
        req[0] = 1'b1; req_addr[7:0] = 8'h10;
        @(posedge clk); @(negedge clk);
        chk("mid_gnt", 32'(gnt), 32'h1);
        rst = 1'b1; req = 2'b00;
        @(negedge clk);
        chk("mid_valid", 32'(rsp_valid), 0);
        chk("mid_busy", 32'(busy), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_valid2", 32'(rsp_valid), 0);
        // ptr must be 0 again: req0 wins a tie
        req = 2'b11; req_addr = 16'h0120;
        @(posedge clk); @(negedge clk);
        chk("post_rst_gnt", 32'(gnt), 32'h1);
        req = 2'b00;
        @(negedge clk);
        chk("post_rst_valid", 32'(rsp_valid), 32'h1);
        chk("post_rst_data", 32'(rsp_data), 32'h66);
        @(negedge clk);

        // 6: req_addr changes during the gnt cycle
        req[0] = 1'b1; req_addr[7:0] = 8'h08;
        @(posedge clk); @(negedge clk);
        chk("late_gnt", 32'(gnt), 32'h1);
        req_addr[7:0] = 8'h10; req[0] = 1'b0;
        @(negedge clk);
        chk("late_valid", 32'(rsp_valid), 32'h1);
        chk("late_data", 32'(rsp_data), 32'h44);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
